risc_wb_arbiter: RTL and testbench
==================================

# risc_wb_arbiter

Writeback arbiter and scoreboard for the 8x8-bit RISC register file. It shares the register file's single write port between the ALU result path and the data-memory load path. It registers the winning write onto the `reg_wr_vld`/`load_op`/`dst`/`rslt`/`dmdataout` bus and tracks a busy bit per register so decode can stall on read-after-write hazards.

## Interface
Parameters:
- `STARVE_MAX`, default 2: maximum consecutive load grants while an ALU write waits (legal range 1..7).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_vld`  in  1  ALU writeback request.
- `alu_rdy`  out  1  ALU request granted this cycle.
- `alu_dst`  in  3  ALU destination register.
- `alu_rslt`  in  8  ALU result.
- `ld_vld`  in  1  load writeback request.
- `ld_rdy`  out  1  load request granted this cycle.
- `ld_dst`  in  3  load destination register.
- `ld_data`  in  8  load data from data memory.
- `iss_vld`  in  1  an instruction that writes `iss_dst` is issued.
- `iss_dst`  in  3  destination of the issued instruction.
- `chk_a_addr`, `chk_b_addr`  in  3 each  operand addresses checked for hazards.
- `stall`  out  1  a checked operand is busy.
- `reg_wr_vld`  out  1  register-file write strobe.
- `load_op`  out  1  selects `dmdataout` (1) or `rslt` (0).
- `dst`  out  3  register-file write address.
- `rslt`  out  8  ALU write data.
- `dmdataout`  out  8  load write data.
- `busy_vec`  out  8  scoreboard; bit i set means register i has a write pending.
- `err`  out  1  sticky flag for issue to an already-busy register.

## Operation
Handshake:
- A transfer happens when `*_vld` and `*_rdy` are both high in the same cycle.
- `*_rdy` is combinational from the valids and the starvation counter. At most one `rdy` is high per cycle.
- Requesters hold `vld` and their payload stable until granted.

Arbitration:
- The load path has priority by default.
- `starve_cnt` (3 bits) increments on each load grant made while `alu_vld` is high.
- When both valids are high and `starve_cnt == STARVE_MAX`, the ALU is granted.
- `starve_cnt` clears on any ALU grant and in any cycle where `alu_vld` is low.
- When only one valid is high, that path is granted regardless of `starve_cnt`.

Write register:
- On a grant, the next edge loads `reg_wr_vld=1` and `dst` from the winner's `*_dst`.
- On a load grant: `load_op=1`, `dmdataout=ld_data`, and `rslt` holds.
- On an ALU grant: `load_op=0`, `rslt=alu_rslt`, and `dmdataout` holds.
- With no grant: `reg_wr_vld=0`, and `dst`, `load_op`, `rslt`, `dmdataout` hold.

Scoreboard:
- `iss_vld` sets `busy[iss_dst]`.
- When `reg_wr_vld` is high, the edge clears `busy[dst]`. This is the same edge on which the register file captures the data.
- If a set and a clear target the same index on the same edge, set wins.
- An `iss_vld` to a register whose busy bit is already 1 leaves the bit at 1 and sets `err`. `err` clears only on reset.
- `stall = busy[chk_a_addr] | busy[chk_b_addr]`, purely combinational. No bypass path.

Reset (`rst` high, asynchronous):
- `reg_wr_vld=0`, `load_op=0`, `dst=0`, `rslt=0x00`, `dmdataout=0x00`.
- `busy_vec=0x00`, `err=0`, `starve_cnt=0`.
- Therefore `stall=0`. `alu_rdy` and `ld_rdy` follow their valids.
- A write registered before reset asserts is discarded.

## Timing
- Grant in cycle N; `reg_wr_vld` and the write bus are valid in N+1.
- The register file writes, and the busy bit clears, at the end of N+1.
- `stall` for that register drops in N+2, when register-file reads return the new value.
- Issue in cycle M: `busy` is set and `stall` is visible in M+1.
- Back-to-back grants produce back-to-back writes with no bubble. Throughput is one write per cycle.
- Reset deassertion: the first grant is possible in the first cycle after release.

## Test plan
- **Single ALU write:** after reset, `iss_vld`/`iss_dst`=3, then `alu_vld`, `alu_dst`=3, `alu_rslt`=0x5A.
  - `alu_rdy` is high the same cycle.
  - Next cycle: `reg_wr_vld=1`, `dst=3`, `load_op=0`, `rslt=0x5A`.
  - `busy_vec[3]` reads 1 until that write cycle ends.
  - With `chk_a_addr=3`, `stall` is 1 until N+2.
- **Load priority and starvation (`STARVE_MAX=2`):** hold `ld_vld` and `alu_vld` high continuously.
  - Grants run load, load, ALU, load, load, ALU.
  - `dmdataout` changes only on load writes; `rslt` changes only on ALU writes.
- **Set/clear collision:** register 5 is busy, its write is in flight (`reg_wr_vld=1`, `dst=5`), and `iss_vld`/`iss_dst=5` arrives in the same cycle.
  - `busy_vec[5]` stays 1.
  - `err` stays 0, because the set and clear share one edge.
- **WAW error:** `iss_dst=2` twice with no intervening write.
  - `err` rises in the cycle after the second issue and stays high until `rst`.
  - `busy_vec[2]` is 1.
- **Reset mid-operation:** assert `rst` in the cycle after a load grant (`dst=6`, `ld_data=0xC3`).
  - All outputs go to their reset values immediately: `reg_wr_vld=0`, `dmdataout=0x00`, `busy_vec=0x00`.
  - After release, a fresh ALU write to `dst=1` completes normally with a one-cycle latency.

Source files
------------

// File: rtl/risc_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : risc_wb_arbiter
// Purpose  : Shares the register-file write port between ALU and load paths
//            and keeps a per-register busy scoreboard for RAW stalls.
// Revision : 1.0
// ============================================================================
module risc_wb_arbiter #(
  parameter int STARVE_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_vld,
  output logic       alu_rdy,
  input  logic [2:0] alu_dst,
  input  logic [7:0] alu_rslt,
  input  logic       ld_vld,
  output logic       ld_rdy,
  input  logic [2:0] ld_dst,
  input  logic [7:0] ld_data,
  input  logic       iss_vld,
  input  logic [2:0] iss_dst,
  input  logic [2:0] chk_a_addr,
  input  logic [2:0] chk_b_addr,
  output logic       stall,
  output logic       reg_wr_vld,
  output logic       load_op,
  output logic [2:0] dst,
  output logic [7:0] rslt,
  output logic [7:0] dmdataout,
  output logic [7:0] busy_vec,
  output logic       err
);

  localparam logic [2:0] c_STARVE_MAX = 3'(STARVE_MAX);

  logic [2:0] r_starve_cnt;
  logic       r_wr_vld;
  logic       r_load_op;
  logic [2:0] r_dst;
  logic [7:0] r_rslt;
  logic [7:0] r_dmdata;
  logic [7:0] r_busy;
  logic       r_err;

  logic       w_alu_gnt;
  logic       w_ld_gnt;
  logic [7:0] w_set_vec;
  logic [7:0] w_clr_vec;
  logic       w_waw;

  // Load wins unless the ALU has waited through STARVE_MAX load grants.
  assign w_alu_gnt = alu_vld & (~ld_vld | (r_starve_cnt == c_STARVE_MAX));
  assign w_ld_gnt  = ld_vld & ~w_alu_gnt;

  assign w_set_vec = iss_vld  ? (8'b1 << iss_dst) : 8'b0;
  assign w_clr_vec = r_wr_vld ? (8'b1 << r_dst)   : 8'b0;
  // A write retiring on the same edge makes the re-issue legal.
  assign w_waw     = iss_vld & r_busy[iss_dst] & ~w_clr_vec[iss_dst];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 3'd0;
    end else if (!alu_vld || w_alu_gnt) begin
      r_starve_cnt <= 3'd0;
    end else if (w_ld_gnt) begin
      r_starve_cnt <= r_starve_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_vld  <= 1'b0;
      r_load_op <= 1'b0;
      r_dst     <= 3'd0;
      r_rslt    <= 8'h00;
      r_dmdata  <= 8'h00;
    end else begin
      r_wr_vld <= w_alu_gnt | w_ld_gnt;
      if (w_alu_gnt) begin
        r_load_op <= 1'b0;
        r_dst     <= alu_dst;
        r_rslt    <= alu_rslt;
      end else if (w_ld_gnt) begin
        r_load_op <= 1'b1;
        r_dst     <= ld_dst;
        r_dmdata  <= ld_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 8'h00;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
      if (w_waw) begin
        r_err <= 1'b1;
      end
    end
  end

  assign alu_rdy    = w_alu_gnt;
  assign ld_rdy     = w_ld_gnt;
  assign stall      = r_busy[chk_a_addr] | r_busy[chk_b_addr];
  assign reg_wr_vld = r_wr_vld;
  assign load_op    = r_load_op;
  assign dst        = r_dst;
  assign rslt       = r_rslt;
  assign dmdataout  = r_dmdata;
  assign busy_vec   = r_busy;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_risc_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_wb_arbiter
// Purpose  : Directed and random checks of risc_wb_arbiter against a
//            cycle-level behavioural model of the writeback rules.
// Revision : 1.0
// ============================================================================
module tb_risc_wb_arbiter;

  localparam int STARVE_MAX = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_vld, ld_vld, iss_vld;
  logic       alu_rdy, ld_rdy, stall;
  logic [2:0] alu_dst, ld_dst, iss_dst, chk_a_addr, chk_b_addr;
  logic [7:0] alu_rslt, ld_data;
  logic       reg_wr_vld, load_op, err;
  logic [2:0] dst;
  logic [7:0] rslt, dmdataout, busy_vec;

  risc_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_vld(alu_vld), .alu_rdy(alu_rdy), .alu_dst(alu_dst), .alu_rslt(alu_rslt),
    .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_dst(ld_dst), .ld_data(ld_data),
    .iss_vld(iss_vld), .iss_dst(iss_dst),
    .chk_a_addr(chk_a_addr), .chk_b_addr(chk_b_addr), .stall(stall),
    .reg_wr_vld(reg_wr_vld), .load_op(load_op), .dst(dst),
    .rslt(rslt), .dmdataout(dmdataout), .busy_vec(busy_vec), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit [7:0] m_busy;
  bit       m_err;
  int       m_starve;
  bit       m_wv, m_lop;
  bit [2:0] m_dst;
  bit [7:0] m_rslt, m_dm;
  bit       last_ga, last_gl;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 8'h00; m_err = 1'b0; m_starve = 0;
    m_wv = 1'b0; m_lop = 1'b0; m_dst = 3'd0; m_rslt = 8'h00; m_dm = 8'h00;
  endtask

  task automatic check_regs();
    chk("reg_wr_vld", 8'(reg_wr_vld), 8'(m_wv));
    chk("load_op",    8'(load_op),    8'(m_lop));
    chk("dst",        8'(dst),        8'(m_dst));
    chk("rslt",       rslt,           m_rslt);
    chk("dmdataout",  dmdataout,      m_dm);
    chk("busy_vec",   busy_vec,       m_busy);
    chk("err",        8'(err),        8'(m_err));
  endtask

  task automatic idle();
    alu_vld = 0; ld_vld = 0; iss_vld = 0;
    alu_dst = 0; ld_dst = 0; iss_dst = 0; alu_rslt = 0; ld_data = 0;
    chk_a_addr = 0; chk_b_addr = 0;
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cycle();
    bit ga, gl;
    bit [7:0] nb;
    bit ne;
    #1;
    ga = alu_vld && (!ld_vld || m_starve == STARVE_MAX);
    gl = ld_vld && !ga;
    chk("alu_rdy", 8'(alu_rdy), 8'(ga));
    chk("ld_rdy",  8'(ld_rdy),  8'(gl));
    chk("stall",   8'(stall),   8'(m_busy[chk_a_addr] | m_busy[chk_b_addr]));
    nb = m_busy; ne = m_err;
    if (m_wv) nb[m_dst] = 1'b0;
    if (iss_vld) begin
      if (m_busy[iss_dst] && !(m_wv && m_dst == iss_dst)) ne = 1'b1;
      nb[iss_dst] = 1'b1;
    end
    if (!alu_vld || ga) m_starve = 0;
    else if (gl)        m_starve = m_starve + 1;
    m_wv = ga || gl;
    if (ga) begin
      m_lop = 1'b0; m_dst = alu_dst; m_rslt = alu_rslt;
    end else if (gl) begin
      m_lop = 1'b1; m_dst = ld_dst; m_dm = ld_data;
    end
    m_busy = nb; m_err = ne;
    last_ga = ga; last_gl = gl;
    @(posedge clk); #1;
    check_regs();
    @(negedge clk);
  endtask

  initial begin
    bit [5:0] pat;
    bit [7:0] prev_r, prev_d;

    // Reset state, rdy follows valid while in reset
    idle();
    rst = 1'b1;
    model_reset();
    alu_vld = 1'b1;
    #12;
    chk("rst_alu_rdy", 8'(alu_rdy), 8'd1);
    chk("rst_stall",   8'(stall),   8'd0);
    check_regs();
    @(negedge clk);
    alu_vld = 1'b0;
    rst = 1'b0;

    // Single ALU write with hazard on r3
    iss_vld = 1; iss_dst = 3;
    cycle();
    iss_vld = 0;
    alu_vld = 1; alu_dst = 3; alu_rslt = 8'h5A; chk_a_addr = 3;
    cycle();
    chk("t1_gnt",    8'(last_ga),    8'd1);
    chk("t1_wr",     8'(reg_wr_vld), 8'd1);
    chk("t1_dst",    8'(dst),        8'd3);
    chk("t1_lop",    8'(load_op),    8'd0);
    chk("t1_rslt",   rslt,           8'h5A);
    chk("t1_busy3",  8'(busy_vec[3]), 8'd1);
    alu_vld = 0;
    #1 chk("t1_stall_n1", 8'(stall), 8'd1);
    cycle();
    #1 chk("t1_stall_n2", 8'(stall), 8'd0);
    chk_a_addr = 0;

    // Load priority / starvation
    pat = 6'b100100;
    alu_vld = 1; alu_dst = 4; alu_rslt = 8'h11;
    ld_vld = 1;  ld_dst = 7;  ld_data = 8'h80;
    for (int i = 0; i < 6; i++) begin
      prev_r = rslt; prev_d = dmdataout;
      cycle();
      chk("starve_gnt", 8'(last_ga), 8'(pat[i]));
      if (last_gl) chk("rslt_hold", rslt, prev_r);
      if (last_ga) chk("dm_hold", dmdataout, prev_d);
      if (last_ga) alu_rslt = alu_rslt + 8'h11;
      if (last_gl) ld_data = ld_data + 8'h01;
    end
    idle();
    cycle();

    // Set/clear collision on r5
    iss_vld = 1; iss_dst = 5;
    cycle();
    iss_vld = 0;
    alu_vld = 1; alu_dst = 5; alu_rslt = 8'h77;
    cycle();
    alu_vld = 0;
    iss_vld = 1; iss_dst = 5;
    cycle();
    iss_vld = 0;
    chk("col_busy5", 8'(busy_vec[5]), 8'd1);
    chk("col_err",   8'(err),         8'd0);

    // WAW error on r2
    iss_vld = 1; iss_dst = 2;
    cycle();
    cycle();
    iss_vld = 0;
    chk("waw_err",   8'(err),         8'd1);
    chk("waw_busy2", 8'(busy_vec[2]), 8'd1);
    cycle();
    cycle();
    chk("waw_sticky", 8'(err), 8'd1);

    // Reset mid-operation after a load grant
    ld_vld = 1; ld_dst = 6; ld_data = 8'hC3;
    cycle();
    ld_vld = 0;
    chk("rm_wr",  8'(reg_wr_vld), 8'd1);
    chk("rm_dm",  dmdataout,      8'hC3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rm_rst_wr",   8'(reg_wr_vld), 8'd0);
    chk("rm_rst_dm",   dmdataout,      8'h00);
    chk("rm_rst_busy", busy_vec,       8'h00);
    check_regs();
    @(negedge clk);
    rst = 1'b0;
    alu_vld = 1; alu_dst = 1; alu_rslt = 8'h3C;
    cycle();
    alu_vld = 0;
    chk("rm_alu_wr",  8'(reg_wr_vld), 8'd1);
    chk("rm_alu_dst", 8'(dst),        8'd1);
    chk("rm_alu_r",   rslt,           8'h3C);

    // Random traffic honouring the hold-until-granted rule
    last_ga = 1; last_gl = 1;
    for (int i = 0; i < 400; i++) begin
      if (!alu_vld || last_ga) begin
        alu_vld  = ($urandom_range(0, 2) != 0);
        alu_dst  = 3'($urandom);
        alu_rslt = 8'($urandom);
      end
      if (!ld_vld || last_gl) begin
        ld_vld  = ($urandom_range(0, 2) != 0);
        ld_dst  = 3'($urandom);
        ld_data = 8'($urandom);
      end
      iss_vld    = ($urandom_range(0, 3) == 0);
      iss_dst    = 3'($urandom);
      chk_a_addr = 3'($urandom);
      chk_b_addr = 3'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
